// File: rtl/sc_regmode.sv
// sc_regmode: universal register with load, shift, rotate, increment, decrement and accumulate.
// Optional saturating arithmetic enabled by defining REGMODE_SATURATE_EN.
module sc_regmode #(
  parameter int                           REGMODE_DATAWIDTH  = 32,
  parameter logic [REGMODE_DATAWIDTH-1:0] REGMODE_RESETVALUE = '0
) (
  input  logic                         SC_REGMODE_CLOCK_50,
  input  logic                         SC_REGMODE_RESET_InHigh,
  input  logic                         SC_REGMODE_clear_InLow,
  input  logic                         SC_REGMODE_load_InLow,
  input  logic [2:0]                   SC_REGMODE_mode_InBUS,
  input  logic                         SC_REGMODE_serial_In,
  input  logic [REGMODE_DATAWIDTH-1:0] SC_REGMODE_data_InBUS,
  output logic [REGMODE_DATAWIDTH-1:0] SC_REGMODE_data_OutBUS,
  output logic                         SC_REGMODE_carry_Out,
  output logic                         SC_REGMODE_zero_Out
);

  localparam int W = REGMODE_DATAWIDTH;

`ifdef REGMODE_SATURATE_EN
  localparam bit SatEn = 1'b1;
`else
  localparam bit SatEn = 1'b0;
`endif

  typedef enum logic [2:0] {
    ModeLoad  = 3'b000,
    ModeShl   = 3'b001,
    ModeShr   = 3'b010,
    ModeRol   = 3'b011,
    ModeRor   = 3'b100,
    ModeInc   = 3'b101,
    ModeDec   = 3'b110,
    ModeAcc   = 3'b111
  } mode_e;

  // Clamp an arithmetic result to its limit on overflow when saturation is built in.
  function automatic logic [W-1:0] saturate(input logic [W-1:0] wrapped,
                                            input logic         ovf,
                                            input logic [W-1:0] limit);
    return (SatEn && ovf) ? limit : wrapped;
  endfunction

  logic [W-1:0] regData_p1;
  logic         carry_p1;
  logic [W-1:0] regData_p0;
  logic         carry_p0;

  logic [W:0] incSum_p0;
  logic [W:0] decDiff_p0;
  logic [W:0] accSum_p0;

  assign incSum_p0  = {1'b0, regData_p1} + (W+1)'(1);
  assign decDiff_p0 = {1'b0, regData_p1} - (W+1)'(1);
  assign accSum_p0  = {1'b0, regData_p1} + {1'b0, SC_REGMODE_data_InBUS};

  // Stage p0: next-state selection from the current register and inputs
  always_comb begin
    regData_p0 = regData_p1;
    carry_p0   = carry_p1;
    if (!SC_REGMODE_clear_InLow) begin
      regData_p0 = '0;
      carry_p0   = 1'b0;
    end else if (!SC_REGMODE_load_InLow) begin
      case (mode_e'(SC_REGMODE_mode_InBUS))
        ModeLoad: begin
          regData_p0 = SC_REGMODE_data_InBUS;
          carry_p0   = 1'b0;
        end
        ModeShl: begin
          regData_p0 = {regData_p1[W-2:0], SC_REGMODE_serial_In};
          carry_p0   = regData_p1[W-1];
        end
        ModeShr: begin
          regData_p0 = {SC_REGMODE_serial_In, regData_p1[W-1:1]};
          carry_p0   = regData_p1[0];
        end
        ModeRol: begin
          regData_p0 = {regData_p1[W-2:0], regData_p1[W-1]};
          carry_p0   = regData_p1[W-1];
        end
        ModeRor: begin
          regData_p0 = {regData_p1[0], regData_p1[W-1:1]};
          carry_p0   = regData_p1[0];
        end
        ModeInc: begin
          regData_p0 = saturate(incSum_p0[W-1:0], incSum_p0[W], '1);
          carry_p0   = incSum_p0[W];
        end
        ModeDec: begin
          // Top bit of the widened difference is the borrow out of zero.
          regData_p0 = saturate(decDiff_p0[W-1:0], decDiff_p0[W], '0);
          carry_p0   = decDiff_p0[W];
        end
        ModeAcc: begin
          regData_p0 = saturate(accSum_p0[W-1:0], accSum_p0[W], '1);
          carry_p0   = accSum_p0[W];
        end
      endcase
    end
  end

  // Stage p1: architectural register and carry
  always_ff @(posedge SC_REGMODE_CLOCK_50 or posedge SC_REGMODE_RESET_InHigh) begin
    if (SC_REGMODE_RESET_InHigh) begin
      regData_p1 <= REGMODE_RESETVALUE;
      carry_p1   <= 1'b0;
    end else begin
      regData_p1 <= regData_p0;
      carry_p1   <= carry_p0;
    end
  end

  assign SC_REGMODE_data_OutBUS = regData_p1;
  assign SC_REGMODE_carry_Out   = carry_p1;
  assign SC_REGMODE_zero_Out    = (regData_p1 == '0);

endmodule

// File: tb/tb_sc_regmode.sv
// Directed self-checking bench for sc_regmode at W=8, reset value 0x3C.
module tb_sc_regmode;

`ifdef REGMODE_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clearN = 1'b1;
  logic       loadN = 1'b1;
  logic [2:0] mode = 3'b000;
  logic       serialIn = 1'b0;
  logic [7:0] dataIn = 8'h00;
  logic [7:0] dataOut;
  logic       carryOut;
  logic       zeroOut;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sc_regmode #(
    .REGMODE_DATAWIDTH (8),
    .REGMODE_RESETVALUE(8'h3C)
  ) dut (
    .SC_REGMODE_CLOCK_50    (clk),
    .SC_REGMODE_RESET_InHigh(rst),
    .SC_REGMODE_clear_InLow (clearN),
    .SC_REGMODE_load_InLow  (loadN),
    .SC_REGMODE_mode_InBUS  (mode),
    .SC_REGMODE_serial_In   (serialIn),
    .SC_REGMODE_data_InBUS  (dataIn),
    .SC_REGMODE_data_OutBUS (dataOut),
    .SC_REGMODE_carry_Out   (carryOut),
    .SC_REGMODE_zero_Out    (zeroOut)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkState(input string tag, input logic [7:0] expData,
                          input logic expCarry, input logic expZero);
    chk({tag, ".data"}, dataOut, expData);
    chk({tag, ".carry"}, {7'b0, carryOut}, {7'b0, expCarry});
    chk({tag, ".zero"}, {7'b0, zeroOut}, {7'b0, expZero});
  endtask

  // Inputs change at the falling edge; one rising edge passes; outputs sampled at the next falling edge.
  task automatic step(input logic ld, input logic [2:0] m, input logic [7:0] d, input logic s);
    loadN    = ld;
    mode     = m;
    dataIn   = d;
    serialIn = s;
    @(negedge clk);
  endtask

  initial begin
    #2 rst = 1'b1;
    #1 chkState("reset", 8'h3C, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 3'b000, 8'h00, 1'b0);
    chkState("resetHold", 8'h3C, 1'b0, 1'b0);

    step(1'b0, 3'b000, 8'hFE, 1'b0);
    chkState("loadFE", 8'hFE, 1'b0, 1'b0);
    step(1'b0, 3'b101, 8'h00, 1'b0);
    chkState("incStream1", 8'hFF, 1'b0, 1'b0);
    step(1'b0, 3'b101, 8'h00, 1'b0);
    chkState("incStream2", SAT ? 8'hFF : 8'h00, 1'b1, !SAT);
    rst = 1'b1;
    #1 chkState("midReset", 8'h3C, 1'b0, 1'b0);
    loadN = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 3'b101, 8'h00, 1'b0);
    step(1'b1, 3'b101, 8'h00, 1'b0);
    chkState("postResetHold", 8'h3C, 1'b0, 1'b0);

    step(1'b0, 3'b000, 8'hA5, 1'b0);
    chkState("loadA5", 8'hA5, 1'b0, 1'b0);
    step(1'b0, 3'b001, 8'h00, 1'b1);
    chkState("shl", 8'h4B, 1'b1, 1'b0);
    step(1'b0, 3'b010, 8'h00, 1'b0);
    chkState("shr", 8'h25, 1'b1, 1'b0);

    step(1'b0, 3'b000, 8'h01, 1'b0);
    step(1'b0, 3'b100, 8'h00, 1'b0);
    chkState("ror", 8'h80, 1'b1, 1'b0);
    step(1'b0, 3'b011, 8'h00, 1'b0);
    chkState("rol", 8'h01, 1'b1, 1'b0);

    step(1'b0, 3'b000, 8'hFF, 1'b0);
    step(1'b0, 3'b101, 8'h00, 1'b0);
    chkState("incFF", SAT ? 8'hFF : 8'h00, 1'b1, !SAT);
    step(1'b0, 3'b000, 8'h00, 1'b0);
    chkState("load00", 8'h00, 1'b0, 1'b1);
    step(1'b0, 3'b110, 8'h00, 1'b0);
    chkState("dec00", SAT ? 8'h00 : 8'hFF, 1'b1, SAT);

    step(1'b0, 3'b000, 8'hF0, 1'b0);
    step(1'b0, 3'b111, 8'h20, 1'b0);
    chkState("accOvf", SAT ? 8'hFF : 8'h10, 1'b1, 1'b0);
    step(1'b0, 3'b000, 8'h10, 1'b0);
    step(1'b0, 3'b111, 8'h01, 1'b0);
    chkState("accNoOvf", 8'h11, 1'b0, 1'b0);
    step(1'b0, 3'b110, 8'h00, 1'b0);
    chkState("dec11", 8'h10, 1'b0, 1'b0);

    step(1'b0, 3'b000, 8'h11, 1'b0);
    step(1'b0, 3'b100, 8'h00, 1'b0);
    chkState("rorCarry", 8'h88, 1'b1, 1'b0);
    step(1'b1, 3'b000, 8'h00, 1'b0);
    step(1'b1, 3'b101, 8'h77, 1'b1);
    step(1'b1, 3'b001, 8'hC3, 1'b0);
    chkState("hold3", 8'h88, 1'b1, 1'b0);

    clearN = 1'b0;
    step(1'b0, 3'b000, 8'h55, 1'b0);
    chkState("clearWins", 8'h00, 1'b0, 1'b1);
    clearN = 1'b1;
    step(1'b0, 3'b000, 8'h55, 1'b0);
    chkState("afterClear", 8'h55, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
